// File: rtl/co_k_rom_pkg.sv
// Shared constants and types for the co_K coefficient ROM arbiter slice.
// The state encoding is fixed here so other shared-resource arbiters can reuse it.
package co_k_rom_pkg;

  localparam int CO_K_ADDR_W  = 10;
  localparam int CO_K_DATA_W  = 20;
  localparam int CO_K_ROM_LAT = 2;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Index width that stays legal for a single requester.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/co_k_rom_arbiter_rr_prio_pick.sv
// Combinational rotating-priority picker: first set bit of req at or above ptr, wrapping.
// Reusable by any round-robin arbiter over N requesters.
module rr_prio_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/co_k_rom_arbiter.sv
// Round-robin arbiter sharing one co_K coefficient ROM among NUM_REQ lanes, with
// locked bursts and a latency pipe that steers each ROM word back to its requester.
module co_k_rom_arbiter
  import co_k_rom_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = CO_K_ADDR_W,
  parameter int DATA_W  = CO_K_DATA_W,
  parameter int ROM_LAT = CO_K_ROM_LAT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_val_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0]        req_lock_i,
  output logic [NUM_REQ-1:0]        req_rdy_o,
  output logic                      rom_en_o,
  output logic [ADDR_W-1:0]         rom_addr_o,
  input  logic [DATA_W-1:0]         rom_data_i,
  output logic [NUM_REQ-1:0]        rsp_val_o,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic                      busy_o
);

  localparam int ID_W = id_w(NUM_REQ);
  localparam int LAST = ROM_LAT - 1;

  arb_state_t                    state_reg, state_next;
  logic [ID_W-1:0]               ptr_reg, ptr_next;
  logic [ID_W-1:0]               owner_reg, owner_next;
  logic [ROM_LAT-1:0]            pipe_val_reg, pipe_val_next;
  logic [ROM_LAT-1:0][ID_W-1:0]  pipe_id_reg;
  logic [ROM_LAT:0]              val_ext;
  logic [ROM_LAT:0][ID_W-1:0]    id_ext;
  logic [NUM_REQ-1:0]            rsp_val_reg;
  logic [DATA_W-1:0]             rsp_data_reg;
  logic                          busy_reg;

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic [NUM_REQ-1:0] rdy;
  logic [ID_W-1:0]    gnt_id;
  logic               xfer;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
    assign addr_arr[gi] = req_addr_i[gi*ADDR_W +: ADDR_W];
  end

  rr_prio_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req   (req_val_i),
    .ptr   (ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    rdy        = '0;
    gnt_id     = '0;
    xfer       = 1'b0;
    if (state_reg == LOCKED) begin
      // Owner keeps ready even while idle so a gap never reopens arbitration.
      rdy    = NUM_REQ'(1) << owner_reg;
      gnt_id = owner_reg;
      xfer   = req_val_i[owner_reg];
    end else begin
      rdy    = pick_grant;
      gnt_id = pick_idx;
      xfer   = pick_any;
    end
    if (xfer) begin
      ptr_next = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + ID_W'(1);
      if (req_lock_i[gnt_id]) begin
        state_next = LOCKED;
        owner_next = gnt_id;
      end else begin
        state_next = ARB;
      end
    end
  end

  assign req_rdy_o  = rst_n ? rdy : '0;
  assign rom_en_o   = rst_n & xfer;
  assign rom_addr_o = addr_arr[gnt_id];

  // Stage 0 takes this cycle's transfer; the top stage lines up with ROM data.
  assign val_ext       = {pipe_val_reg, xfer};
  assign id_ext        = {pipe_id_reg, gnt_id};
  assign pipe_val_next = val_ext[ROM_LAT-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ARB;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      pipe_val_reg <= '0;
      pipe_id_reg  <= '0;
      rsp_val_reg  <= '0;
      rsp_data_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      owner_reg    <= owner_next;
      pipe_val_reg <= pipe_val_next;
      pipe_id_reg  <= id_ext[ROM_LAT-1:0];
      rsp_val_reg  <= pipe_val_reg[LAST] ? (NUM_REQ'(1) << pipe_id_reg[LAST]) : '0;
      if (pipe_val_reg[LAST]) begin
        rsp_data_reg <= rom_data_i;
      end
      busy_reg <= (|pipe_val_next) | (state_next == LOCKED);
    end
  end

  assign rsp_val_o  = rsp_val_reg;
  assign rsp_data_o = rsp_data_reg;
  assign busy_o     = busy_reg;

endmodule
